// File: rtl/iopmp_err_capture_ctrl.sv
// IOPMP error-record capture: round-robin arbitration of violation sources into a
// single held error record, with stall-or-drop handling and a saturating drop counter.
module iopmp_err_capture_ctrl #(
    parameter int NumReq    = 4,
    parameter int AddrWidth = 32,
    parameter int RidWidth  = 8,
    parameter int CntWidth  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NumReq-1:0]             viol_valid,
    output logic [NumReq-1:0]             viol_ready,
    input  logic [NumReq*AddrWidth-1:0]   viol_addr,
    input  logic [NumReq*RidWidth-1:0]    viol_rid,
    input  logic [NumReq*2-1:0]           viol_ttype,
    input  logic                          sw_err_clr,
    input  logic                          sw_cnt_clr,
    input  logic                          stall_en,
    input  logic                          irq_en,
    output logic                          err_valid,
    output logic [AddrWidth-1:0]          err_addr,
    output logic [RidWidth-1:0]           err_rid,
    output logic [1:0]                    err_ttype,
    output logic [$clog2(NumReq)-1:0]     err_src,
    output logic [CntWidth-1:0]           drop_cnt,
    output logic                          irq
);

    localparam int SrcW = $clog2(NumReq);
    localparam int PopW = $clog2(NumReq + 1);
    localparam int SumW = CntWidth + PopW;
    localparam logic [CntWidth-1:0] CntMax = '1;

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } state_t;

    state_t                state_reg, state_next;
    logic [SrcW-1:0]       rr_ptr_reg;
    logic                  err_valid_reg;
    logic [AddrWidth-1:0]  err_addr_reg;
    logic [RidWidth-1:0]   err_rid_reg;
    logic [1:0]            err_ttype_reg;
    logic [SrcW-1:0]       err_src_reg;
    logic [CntWidth-1:0]   drop_cnt_reg;

    logic [AddrWidth-1:0]  addr_arr  [NumReq];
    logic [RidWidth-1:0]   rid_arr   [NumReq];
    logic [1:0]            ttype_arr [NumReq];

    generate
        for (genvar gi = 0; gi < NumReq; gi++) begin : g_unpack
            assign addr_arr[gi]  = viol_addr[gi*AddrWidth +: AddrWidth];
            assign rid_arr[gi]   = viol_rid[gi*RidWidth +: RidWidth];
            assign ttype_arr[gi] = viol_ttype[gi*2 +: 2];
        end
    endgenerate

    // Round-robin search starting at rr_ptr, wrapping modulo NumReq
    logic            grant_found;
    logic [SrcW-1:0] grant_idx;
    logic [SrcW:0]   cand;
    logic [SrcW-1:0] cand_s;
    logic [SrcW-1:0] rr_ptr_next;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        cand_s      = '0;
        for (int k = 0; k < NumReq; k++) begin
            cand = {1'b0, rr_ptr_reg} + (SrcW+1)'(k);
            if (cand >= (SrcW+1)'(NumReq)) begin
                cand = cand - (SrcW+1)'(NumReq);
            end
            cand_s = cand[SrcW-1:0];
            if (!grant_found && viol_valid[cand_s]) begin
                grant_found = 1'b1;
                grant_idx   = cand_s;
            end
        end
        rr_ptr_next = (grant_idx == SrcW'(NumReq - 1)) ? '0 : grant_idx + SrcW'(1);
    end

    always_comb begin
        state_next = state_reg;
        viol_ready = '0;
        case (state_reg)
            IDLE: begin
                if (grant_found) begin
                    viol_ready[grant_idx] = 1'b1;
                    state_next            = HELD;
                end
            end
            HELD: begin
                if (!stall_en) begin
                    viol_ready = viol_valid;
                end
                if (sw_err_clr) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Saturating drop-count update
    logic [PopW-1:0]     pop;
    logic [SumW-1:0]     cnt_sum;
    logic [CntWidth-1:0] cnt_sat;
    logic                drop_inc;

    always_comb begin
        pop = '0;
        for (int i = 0; i < NumReq; i++) begin
            pop = pop + PopW'(viol_valid[i]);
        end
        cnt_sum  = SumW'(drop_cnt_reg) + SumW'(pop);
        cnt_sat  = (cnt_sum > SumW'(CntMax)) ? CntMax : cnt_sum[CntWidth-1:0];
        drop_inc = (state_reg == HELD) && !stall_en && (|viol_valid);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= '0;
            err_valid_reg <= 1'b0;
            err_addr_reg  <= '0;
            err_rid_reg   <= '0;
            err_ttype_reg <= '0;
            err_src_reg   <= '0;
            drop_cnt_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && grant_found) begin
                err_valid_reg <= 1'b1;
                err_addr_reg  <= addr_arr[grant_idx];
                err_rid_reg   <= rid_arr[grant_idx];
                err_ttype_reg <= ttype_arr[grant_idx];
                err_src_reg   <= grant_idx;
                rr_ptr_reg    <= rr_ptr_next;
            end else if (state_reg == HELD && sw_err_clr) begin
                err_valid_reg <= 1'b0;
            end
            // Software clear takes precedence over a same-cycle drop
            if (sw_cnt_clr) begin
                drop_cnt_reg <= '0;
            end else if (drop_inc) begin
                drop_cnt_reg <= cnt_sat;
            end
        end
    end

    assign err_valid = err_valid_reg;
    assign err_addr  = err_addr_reg;
    assign err_rid   = err_rid_reg;
    assign err_ttype = err_ttype_reg;
    assign err_src   = err_src_reg;
    assign drop_cnt  = drop_cnt_reg;
    assign irq       = err_valid_reg & irq_en;

endmodule

// File: doc/iopmp_err_capture_ctrl.md
Name: iopmp_err_capture_ctrl

Overview:
- Sequences and arbitrates the IOPMP error-record registers (err_addr, err_rid, err_ttype, err_valid, drop counter) between NumReq violation sources (per-port checkers) and the software control port.
- Round-robin selects one violation, captures it, and holds it until software clears it.
- While a record is held, further violations are either dropped and counted, or stalled, depending on a configuration input.
- Feeds the register file and the interrupt line.

Parameters:
- NumReq, 4, number of violation requesters (≥2).
- AddrWidth, 32, violating address width.
- RidWidth, 8, requester-ID width.
- CntWidth, 8, saturating drop-counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- viol_valid  in  NumReq  per-requester violation pending.
- viol_ready  out  NumReq  per-requester violation accepted (combinational).
- viol_addr  in  NumReq*AddrWidth  packed; requester i at [i*AddrWidth +: AddrWidth].
- viol_rid  in  NumReq*RidWidth  packed, same indexing.
- viol_ttype  in  NumReq*2  packed, same indexing; 0=read, 1=write, 2=exec.
- sw_err_clr  in  1  one-cycle pulse: SW wrote 1 to err_valid (W1C).
- sw_cnt_clr  in  1  one-cycle pulse: SW cleared the drop counter.
- stall_en  in  1  1 = stall requesters while held; 0 = drop and count.
- irq_en  in  1  interrupt enable from config register.
- err_valid  out  1  record held.
- err_addr  out  AddrWidth  captured address.
- err_rid  out  RidWidth  captured RID.
- err_ttype  out  2  captured transaction type.
- err_src  out  $clog2(NumReq)  index of the captured requester.
- drop_cnt  out  CntWidth  dropped violations, saturating.
- irq  out  1  err_valid & irq_en (combinational from registered err_valid).

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, rr_ptr=0, err_valid=0, err_addr/err_rid/err_ttype/err_src=0, drop_cnt=0; viol_ready=0 and irq=0 follow combinationally.
- Reset mid-HELD discards the record and the counter; no capture occurs in the reset cycle.
- Arbitration (IDLE only): the grant g is the first i with viol_valid[i], searching rr_ptr, rr_ptr+1, … modulo NumReq.
  - viol_ready[g]=1 in that cycle; all other viol_ready bits are 0.
- Capture: on a handshake cycle, the next posedge latches viol_*[g] into err_*, sets err_src=g, err_valid=1 and rr_ptr=(g+1) mod NumReq, and moves state to HELD.
- Latency: violation presented → err_valid/irq high after exactly 1 clock.
- In IDLE with no viol_valid, nothing changes.
- HELD, stall_en=0: viol_ready=viol_valid (all accepted and discarded).
  - drop_cnt += popcount(viol_valid), saturating at 2^CntWidth-1 (never wraps).
  - err_* and rr_ptr are unchanged.
- HELD, stall_en=1: viol_ready=0; drop_cnt is unchanged.
- stall_en is sampled every cycle; toggling it while HELD takes effect in the same cycle.
- HELD → IDLE on sw_err_clr. The next posedge clears err_valid; err_addr/err_rid/err_ttype/err_src keep their last values.
- sw_err_clr and viol_valid in the same HELD cycle: the violation follows the HELD rules for that cycle (dropped or stalled). Capture can happen at the earliest in the following IDLE cycle.
- sw_err_clr in IDLE: ignored.
- sw_cnt_clr: drop_cnt becomes 0 at the next posedge. If a drop increment happens in the same cycle, the clear wins and the result is 0.
- Only one record is ever held: there is no queue.
- State encoding: 2 states (IDLE, HELD), registered; all outputs are registered except viol_ready and irq.

Test Plan:
- Reset then idle: no viol_valid for 5 cycles → err_valid=0, drop_cnt=0, viol_ready=0, irq=0.
- Single capture: irq_en=1; viol_valid=4'b0100, addr[2]=0x8000_1000, rid[2]=0x05, ttype[2]=1.
  - Expect viol_ready=4'b0100 in that cycle.
  - Next cycle: err_valid=1, err_addr=0x8000_1000, err_rid=0x05, err_ttype=1, err_src=2, irq=1.
- Round-robin fairness: hold viol_valid=4'b1111, stall_en=0, and pulse sw_err_clr each time err_valid rises.
  - Expect err_src sequence 0,1,2,3,0.
  - drop_cnt increases by 4 in each HELD cycle.
- Stall mode while HELD: stall_en=1, viol_valid=4'b0011 → viol_ready=0 and drop_cnt unchanged.
  - After sw_err_clr, capture src=0 (when rr_ptr=0).
- Saturation and clear precedence: CntWidth=8, preload drop_cnt=253 via drops, then 2 cycles of 4 drops → drop_cnt=255.
  - Then sw_cnt_clr together with a drop → drop_cnt=0.
- Simultaneous clear and violation: HELD, sw_err_clr=1 with viol_valid=4'b0001, stall_en=0.
  - Expect that violation dropped (drop_cnt+1) and err_valid=0 next cycle.
  - With viol_valid still high, capture the cycle after.
